// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame read-only instruction cache.
// Define ICACHE_STATS_EN to add the hit_count/miss_count outputs.
module icache_responder #(
  parameter int unsigned INDEX_BITS = 4,
  parameter logic [31:0] PC_INIT    = 32'h0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  input  logic        iflush
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned FRAMES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W  = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    FETCH
  } state_e;

  state_e                  state_q;
  logic                    iren_q;
  logic [31:0]             iaddr_q;
  logic [FRAMES-1:0]       valid_q;
  logic [TAG_W-1:0]        tag_q  [FRAMES];
  logic [31:0]             data_q [FRAMES];

  logic [INDEX_BITS-1:0]   rd_idx;
  logic [INDEX_BITS-1:0]   wr_idx;
  logic [TAG_W-1:0]        rd_tag;
  logic [TAG_W-1:0]        wr_tag;
  logic                    lookup;
  logic                    start;
  logic                    fill;

  assign rd_idx = imemaddr[INDEX_BITS+1:2];
  assign rd_tag = imemaddr[31:INDEX_BITS+2];
  assign wr_idx = iaddr_q[INDEX_BITS+1:2];
  assign wr_tag = iaddr_q[31:INDEX_BITS+2];

  assign lookup = valid_q[rd_idx]
               && (tag_q[rd_idx] == rd_tag);

  assign ihit = imemREN
             && (state_q == IDLE)
             && lookup
             && !iflush;

  assign imemload = ihit ? data_q[rd_idx] : 32'h0;

  assign start = (state_q == IDLE)
              && imemREN
              && !lookup
              && !iflush;

  assign fill = (state_q == FETCH) && !iwait;

  assign iREN  = iren_q;
  assign iaddr = iaddr_q;

  // iaddr_q doubles as the captured miss address while in FETCH
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      iren_q  <= 1'b0;
      iaddr_q <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            iren_q  <= 1'b1;
            iaddr_q <= {imemaddr[31:2], 2'b00};
          end
        end
        FETCH: begin
          if (!iwait) begin
            state_q <= IDLE;
            iren_q  <= 1'b0;
            iaddr_q <= 32'h0;
          end
        end
        default: begin
          state_q <= IDLE;
          iren_q  <= 1'b0;
          iaddr_q <= 32'h0;
        end
      endcase
    end
  end

  // flush beats a coincident fill, leaving that frame invalid
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (iflush) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      if (ihit) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (start) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{PC_INIT, imemaddr[1:0], iaddr_q[1:0]};

endmodule
